// File: rtl/exp_engine.sv
// ============================================================================
//  Module      : exp_engine
//  Description : Fixed-point e^x * 2^ui via truncated Taylor series on one
//                shared multiplier, with valid/ready operand and result ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp_engine #(
  parameter int FRAC_W = 5,
  parameter int F      = 16,
  parameter int INT_W  = 2,
  parameter int UI_W   = 2,
  parameter int TERMS  = 8,
  localparam int OUT_W = INT_W + F + (1 << UI_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic [UI_W-1:0]   in_ui,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  localparam int SUM_W = INT_W + F;
  localparam logic [F:0]       c_one     = {1'b1, {F{1'b0}}};
  localparam logic [SUM_W-1:0] c_oneSum  = SUM_W'(c_one);
  localparam logic [3:0]       c_lastK   = 4'(TERMS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    MUL_X = 3'd2,
    MUL_C = 3'd3,
    DONE  = 3'd4
  } stateT;

  stateT            r_state;
  logic [F-1:0]     r_x;
  logic [UI_W-1:0]  r_ui;
  logic [F-1:0]     r_term;
  logic [SUM_W-1:0] r_sum;
  logic [3:0]       r_k;
  logic [OUT_W-1:0] r_outData;
  logic             r_outValid;

  // Reciprocal coefficients floor(2^F / k); entries 0 and 1 are never selected.
  logic [F-1:0] w_coefTable [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_coef
      if (gi < 2) begin : g_unusedSlot
        assign w_coefTable[gi] = '0;
      end else begin : g_recip
        assign w_coefTable[gi] = F'(c_one / (F+1)'(gi));
      end
    end
  endgenerate

  logic [F-1:0]     w_mulB;
  logic [F-1:0]     w_mulOut;
  logic [F-1:0]     w_unusedProdLo;
  logic [SUM_W-1:0] w_sumNext;

  // Single shared multiplier: operand B alternates between x and C_k.
  always_comb begin
    w_mulB = (r_state == MUL_X) ? r_x : w_coefTable[r_k];
    {w_mulOut, w_unusedProdLo} = r_term * w_mulB;
    w_sumNext = r_sum + SUM_W'(w_mulOut);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_ui       <= '0;
      r_term     <= '0;
      r_sum      <= '0;
      r_k        <= '0;
      r_outData  <= '0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= F'(in_frac) << (F - FRAC_W);
            r_ui    <= in_ui;
            r_state <= INIT;
          end
        end
        INIT: begin
          r_term  <= r_x;
          r_sum   <= c_oneSum + SUM_W'(r_x);
          r_k     <= 4'd2;
          r_state <= MUL_X;
        end
        MUL_X: begin
          r_term  <= w_mulOut;
          r_state <= MUL_C;
        end
        MUL_C: begin
          r_term <= w_mulOut;
          r_sum  <= w_sumNext;
          r_k    <= r_k + 4'd1;
          if (r_k == c_lastK) begin
            r_outData  <= OUT_W'(w_sumNext) << r_ui;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_state <= MUL_X;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_outValid;
  assign out_data  = r_outData;

endmodule

`default_nettype wire

// File: doc/exp_engine.md
# exp_engine

Parametrised fixed-point exponential unit: accepts a fractional operand x in [0,1) and a power-of-two scale ui, evaluates e^x with a truncated Taylor series on a single shared multiplier, and returns e^x·2^ui. It succeeds the fixed 5-bit/2-bit exponential datapath. Differences from that datapath:
- Widths and term count are generic.
- The controller is internal.
- Operands are latched on a valid/ready handshake, with no separate load or shift strobes.
- The result is held until the consumer takes it.

## Interface
- FRAC_W, default 5: input fraction bits; x = in_frac / 2^FRAC_W.
- F, default 16: internal fraction bits; must satisfy F ≥ FRAC_W.
- INT_W, default 2: integer bits of the sum; must hold e^1.
- UI_W, default 2: scale-select width.
- TERMS, default 8: series terms, counting the constant 1; legal range is 3..16.
- OUT_W, derived, equals INT_W + F + 2^UI_W − 1 (21 with defaults).

Ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  engine idle; an operand is accepted when in_valid && in_ready at a rising edge.
- in_frac  in  FRAC_W  fractional operand.
- in_ui  in  UI_W  left-shift amount applied to the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  OUT_W  unsigned Q(INT_W+2^UI_W−1).F, equal to sum << ui.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, INIT, MUL_X, MUL_C, DONE.
- Registers:
  - x (F bits)
  - ui (UI_W bits)
  - term (F bits)
  - sum (INT_W+F bits)
  - k (4 bits)
  - out_data (OUT_W bits)
- IDLE: in_ready=1. On accept, latch x = in_frac << (F−FRAC_W) and ui = in_ui, then go to INIT. Inputs outside an accept are ignored.
- INIT: term ← x; sum ← 2^F + x; k ← 2; go to MUL_X.
- MUL_X: term ← floor(term·x / 2^F); go to MUL_C.
- MUL_C: term ← floor(term·C_k / 2^F), where C_k = floor(2^F / k) is a compile-time constant.
  - In the same cycle, sum ← sum + that new term value.
  - k ← k+1.
  - If k == TERMS−1, go to DONE and register out_data ← zero-extended sum << ui. Otherwise go to MUL_X.
- DONE: out_valid=1, and out_data is held stable. On out_ready, go to IDLE, clear out_valid, and keep out_data unchanged.
- Arithmetic:
  - All products are unsigned, at full width (2F), then truncated by dropping the low F bits.
  - sum wraps modulo 2^(INT_W+F) with no saturation; defaults cannot overflow.
- Only one multiplier is used; it is muxed between x and C_k.
- in_ready is a combinational decode of state==IDLE. There is no accept in DONE, even when out_ready=1.

## Timing
- Reset is asynchronous while rst=1:
  - state=IDLE
  - out_valid=0
  - out_data=0
  - busy=0
  - in_ready=1
  - term, sum, x, ui and k are all cleared to 0.
- Reset mid-computation aborts the operation. No partial result appears, and the first accept after rst falls behaves normally.
- Latency: if accept occurs at edge A, out_valid rises after edge A + 2·TERMS − 3, which is edge A+13 with defaults.
- Throughput: the next accept is possible at the edge after the cycle in which out_ready is seen with out_valid=1. Minimum issue interval is 2·TERMS − 1 cycles with out_ready tied high.
- busy rises after the accept edge and falls after the out_ready handshake edge.
- out_data changes only on the DONE-entry edge and on reset.

## Test plan
- Reset and idle:
  - Stimulus: hold rst for 3 cycles, with in_valid toggling during reset.
  - Required: out_valid=0, out_data=0 and in_ready=1 throughout; no accept until rst=0.
- Zero operand, defaults:
  - Stimulus: in_frac=0, ui=0.
  - Required: out_valid exactly 13 cycles after the accept edge; out_data=0x10000.
  - Stimulus: repeat with ui=3.
  - Required: out_data=0x80000.
- Midpoint:
  - Stimulus: in_frac=5'b10000 (x=0.5), ui=1.
  - Required: out_data equals the bit-exact model (sum ≈ 108050 ±8, then <<1); the result must not exceed floor(e^0.5·2^16)·2.
- Backpressure:
  - Stimulus: in_frac=31, out_ready held low for 20 cycles; in_valid held high with a second operand.
  - Required: out_data stable, busy=1, in_ready=0 and the second operand not accepted. When out_ready pulses, the second operand is accepted one edge later.
- Mid-operation reset:
  - Stimulus: assert rst 6 cycles after accept.
  - Required: outputs return to reset values immediately (asynchronously); a fresh operand afterwards yields the correct result at the 13-cycle latency.
- Parameter sweep:
  - Stimulus: FRAC_W=8, F=20, TERMS=12, UI_W=3, with random operands.
  - Required: bit-exact match to the model; latency 21 cycles; OUT_W=29.
